// File: rtl/inst_enc_pkg.sv
// Shared opcodes, format/error encodings and the NOP word for the RV32 instruction encoder.
package inst_enc_pkg;

  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_I_JALR  = 7'b1100111;
  localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_I_ALU   = 7'b0010011;
  localparam logic [6:0] OP_S       = 7'b0100011;
  localparam logic [6:0] OP_B       = 7'b1100011;
  localparam logic [6:0] OP_U_LUI   = 7'b0110111;
  localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_J       = 7'b1101111;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_OPCODE   = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

endpackage

// File: rtl/inst_enc_chk.sv
// Combinational format select plus immediate range/alignment check.
// Error priority: bad opcode, then misalignment, then range.
module inst_enc_chk
  import inst_enc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] imm,
  output fmt_e                  fmt,
  output err_code_e             err_code
);

  logic eq_11, eq_12, eq_20, eq_31, hi_5_zero;
  logic misalign, range_ok;

  // "all equal" means the upper bits are a pure sign extension
  assign eq_11     = (&imm[DATA_WIDTH-1:11]) | ~(|imm[DATA_WIDTH-1:11]);
  assign eq_12     = (&imm[DATA_WIDTH-1:12]) | ~(|imm[DATA_WIDTH-1:12]);
  assign eq_20     = (&imm[DATA_WIDTH-1:20]) | ~(|imm[DATA_WIDTH-1:20]);
  assign eq_31     = (&imm[DATA_WIDTH-1:31]) | ~(|imm[DATA_WIDTH-1:31]);
  assign hi_5_zero = ~(|imm[DATA_WIDTH-1:5]);

  always_comb begin
    fmt = FMT_BAD;
    case (opcode)
      OP_R:                  fmt = FMT_R;
      OP_I_JALR, OP_I_LOAD:  fmt = FMT_I;
      OP_I_ALU:              fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_ISH : FMT_I;
      OP_S:                  fmt = FMT_S;
      OP_B:                  fmt = FMT_B;
      OP_U_LUI, OP_U_AUIPC:  fmt = FMT_U;
      OP_J:                  fmt = FMT_J;
      default:               fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    range_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: range_ok = eq_11;
      FMT_ISH:      range_ok = hi_5_zero;
      FMT_B: begin
        range_ok = eq_12;
        misalign = imm[0];
      end
      FMT_U: begin
        range_ok = eq_31;
        misalign = |imm[11:0];
      end
      FMT_J: begin
        range_ok = eq_20;
        misalign = imm[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    err_code = ERR_NONE;
    if (fmt == FMT_BAD)  err_code = ERR_OPCODE;
    else if (misalign)   err_code = ERR_MISALIGN;
    else if (!range_ok)  err_code = ERR_RANGE;
  end

endmodule

// File: rtl/inst_enc.sv
// Two-stage RV32 instruction encoder: S1 holds the check result and fields, S2 the packed word.
// Define INST_ENC_STAT_EN to add the saturating error-transfer counter o_stat_err_cnt.
module inst_enc
  import inst_enc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [6:0]            i_opcode,
  input  logic [4:0]            i_rd,
  input  logic [4:0]            i_rs1,
  input  logic [4:0]            i_rs2,
  input  logic [2:0]            i_funct3,
  input  logic [6:0]            i_funct7,
  input  logic [DATA_WIDTH-1:0] i_imm,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [31:0]           o_inst,
  output logic                  o_err,
  output logic [1:0]            o_err_code
`ifdef INST_ENC_STAT_EN
  ,
  output logic [15:0]           o_stat_err_cnt
`endif
);

  fmt_e      chk_fmt;
  err_code_e chk_err;

  logic        s1_valid;
  fmt_e        s1_fmt;
  err_code_e   s1_err;
  logic [6:0]  s1_op;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [2:0]  s1_f3;
  logic [6:0]  s1_f7;
  logic [31:0] s1_imm;
  logic [31:0] packed_inst;
  logic        s2_load;

  inst_enc_chk #(.DATA_WIDTH(DATA_WIDTH)) u_chk (
    .opcode   (i_opcode),
    .funct3   (i_funct3),
    .imm      (i_imm),
    .fmt      (chk_fmt),
    .err_code (chk_err)
  );

  assign s2_load = !o_valid || i_ready;
  assign o_ready = !s1_valid || s2_load;

  // Payload needs no reset: it is only consumed behind s1_valid
  always_ff @(posedge i_clk) begin
    if (i_valid && o_ready) begin
      s1_fmt <= chk_fmt;
      s1_err <= chk_err;
      s1_op  <= i_opcode;
      s1_rd  <= i_rd;
      s1_rs1 <= i_rs1;
      s1_rs2 <= i_rs2;
      s1_f3  <= i_funct3;
      s1_f7  <= i_funct7;
      s1_imm <= i_imm[31:0];
    end
  end

  always_comb begin
    packed_inst = INST_NOP;
    if (s1_err == ERR_NONE) begin
      case (s1_fmt)
        FMT_R:   packed_inst = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
        FMT_I:   packed_inst = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
        FMT_ISH: packed_inst = {s1_f7, s1_imm[4:0], s1_rs1, s1_f3, s1_rd, s1_op};
        FMT_S:   packed_inst = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
        FMT_B:   packed_inst = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                                s1_imm[4:1], s1_imm[11], s1_op};
        FMT_U:   packed_inst = {s1_imm[31:12], s1_rd, s1_op};
        FMT_J:   packed_inst = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                s1_rd, s1_op};
        default: packed_inst = INST_NOP;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid   <= 1'b0;
      o_valid    <= 1'b0;
      o_inst     <= '0;
      o_err      <= 1'b0;
      o_err_code <= '0;
    end else begin
      if (o_ready) s1_valid <= i_valid;
      if (s2_load) begin
        o_valid <= s1_valid;
        if (s1_valid) begin
          o_inst     <= packed_inst;
          o_err      <= (s1_err != ERR_NONE);
          o_err_code <= s1_err;
        end
      end
    end
  end

`ifdef INST_ENC_STAT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stat_err_cnt <= '0;
    end else if (o_valid && i_ready && o_err && o_stat_err_cnt != 16'hFFFF) begin
      o_stat_err_cnt <= o_stat_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_enc.sv
// Directed and round-trip bench for inst_enc; expected words are hand-computed RV32 encodings.
module tb_inst_enc;

  logic        i_clk, i_rst_n, i_valid, o_ready, o_valid, i_ready, o_err;
  logic [6:0]  i_opcode, i_funct7;
  logic [4:0]  i_rd, i_rs1, i_rs2;
  logic [2:0]  i_funct3;
  logic [31:0] i_imm, o_inst;
  logic [1:0]  o_err_code;
`ifdef INST_ENC_STAT_EN
  logic [15:0] o_stat_err_cnt;
`endif

  int total = 0;
  int passed = 0;

  inst_enc #(.DATA_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm),
    .o_valid(o_valid), .i_ready(i_ready), .o_inst(o_inst),
    .o_err(o_err), .o_err_code(o_err_code)
`ifdef INST_ENC_STAT_EN
    , .o_stat_err_cnt(o_stat_err_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference RV32 immediate decoder
  function automatic logic [31:0] imm_dec(input logic [31:0] w);
    case (w[6:0])
      7'b1100111, 7'b0000011, 7'b0010011: imm_dec = {{20{w[31]}}, w[31:20]};
      7'b0100011: imm_dec = {{20{w[31]}}, w[31:25], w[11:7]};
      7'b1100011: imm_dec = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm_dec = {w[31:12], 12'b0};
      7'b1101111: imm_dec = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm_dec = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
    i_opcode = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
    i_funct3 = f3; i_funct7 = f7; i_imm = imm;
  endtask

  // Single request through an empty pipe; lat counts clock edges from handshake to o_valid
  task automatic do_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, output logic [31:0] inst, output logic err,
                        output logic [1:0] code, output int lat);
    int n;
    @(negedge i_clk);
    set_req(op, rd, rs1, rs2, f3, f7, imm);
    i_ready = 1'b1;
    i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    @(posedge i_clk);
    lat = 1;
    @(negedge i_clk);
    i_valid = 1'b0;
    while (!o_valid && lat < 20) begin
      @(posedge i_clk);
      lat++;
      @(negedge i_clk);
    end
    inst = o_valid ? o_inst : 32'hxxxx_xxxx;
    err  = o_valid ? o_err : 1'bx;
    code = o_valid ? o_err_code : 2'bxx;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    set_req(7'h13, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge i_clk);
    total++; if (o_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", o_valid); else passed++;
    total++; if (o_inst !== 32'h0) $display("FAIL rst_inst got %h exp 0", o_inst); else passed++;
    total++; if (o_err !== 1'b0 || o_err_code !== 2'd0)
      $display("FAIL rst_err got %b/%0d exp 0/0", o_err, o_err_code); else passed++;
    i_rst_n = 1'b1;
    #1;
    total++; if (o_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", o_ready); else passed++;
  endtask

  task automatic test_addi();
    logic [31:0] inst; logic err; logic [1:0] code; int lat;
    do_req(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, inst, err, code, lat);
    total++; if (inst !== 32'hFFF1_0093) $display("FAIL addi_inst got %h exp fff10093", inst); else passed++;
    total++; if (err !== 1'b0) $display("FAIL addi_err got %b exp 0", err); else passed++;
    total++; if (lat !== 2) $display("FAIL addi_latency got %0d exp 2", lat); else passed++;
  endtask

  task automatic test_beq();
    logic [31:0] inst; logic err; logic [1:0] code; int lat;
    do_req(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, inst, err, code, lat);
    total++; if (inst !== 32'hFE20_8EE3) $display("FAIL beq_inst got %h exp fe208ee3", inst); else passed++;
    do_req(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, inst, err, code, lat);
    total++; if (inst !== 32'h0000_0013 || err !== 1'b1 || code !== 2'd2)
      $display("FAIL beq_misalign got %h/%b/%0d exp 00000013/1/2", inst, err, code); else passed++;
  endtask

  task automatic test_jal();
    logic [31:0] inst; logic err; logic [1:0] code; int lat;
    do_req(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, inst, err, code, lat);
    total++; if (inst !== 32'h0010_00EF) $display("FAIL jal_inst got %h exp 001000ef", inst); else passed++;
    do_req(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, inst, err, code, lat);
    total++; if (inst !== 32'h0000_0013 || err !== 1'b1 || code !== 2'd1)
      $display("FAIL jal_range got %h/%b/%0d exp 00000013/1/1", inst, err, code); else passed++;
  endtask

  task automatic test_srai();
    logic [31:0] inst; logic err; logic [1:0] code; int lat;
    do_req(7'b0010011, 5'd3, 5'd4, 5'd0, 3'b101, 7'b0100000, 32'd31, inst, err, code, lat);
    total++; if (inst !== 32'h41F2_5193) $display("FAIL srai_inst got %h exp 41f25193", inst); else passed++;
    do_req(7'b0010011, 5'd3, 5'd4, 5'd0, 3'b101, 7'b0100000, 32'd32, inst, err, code, lat);
    total++; if (inst !== 32'h0000_0013 || code !== 2'd1)
      $display("FAIL srai_range got %h/%0d exp 00000013/1", inst, code); else passed++;
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic [1:0]  exp_code;
  } vec_t;

  task automatic test_formats();
    vec_t tbl[12];
    logic [31:0] inst; logic err; logic [1:0] code; int lat;
    tbl[0]  = '{7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 32'h0000_1234, 32'h0020_81B3, 2'd0};
    tbl[1]  = '{7'b0100011, 5'd0, 5'd6, 5'd5, 3'd2, 32'hFFFF_FFF8, 32'hFE53_2C23, 2'd0};
    tbl[2]  = '{7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 32'h1234_52B7, 2'd0};
    tbl[3]  = '{7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001, 32'h0000_0013, 2'd2};
    tbl[4]  = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2047,      32'h7FF0_0093, 2'd0};
    tbl[5]  = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048,      32'h0000_0013, 2'd1};
    tbl[6]  = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_F800, 32'h8000_0093, 2'd0};
    tbl[7]  = '{7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4097,      32'h0000_0013, 2'd2};
    tbl[8]  = '{7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4096,      32'h0000_0013, 2'd1};
    tbl[9]  = '{7'b0000011, 5'd7, 5'd8, 5'd0, 3'd2, 32'd16,        32'h0104_2383, 2'd0};
    tbl[10] = '{7'b0010111, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_F000, 32'hFFFF_F097, 2'd0};
    tbl[11] = '{7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFE, 32'hFFFF_F06F, 2'd0};
    for (int i = 0; i < 12; i++) begin
      do_req(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3, 7'd0, tbl[i].imm,
             inst, err, code, lat);
      total++;
      if (inst !== tbl[i].exp_inst || code !== tbl[i].exp_code || err !== (tbl[i].exp_code != 2'd0))
        $display("FAIL fmt_vec%0d got %h/%b/%0d exp %h/%0d", i, inst, err, code,
                 tbl[i].exp_inst, tbl[i].exp_code);
      else passed++;
    end
  endtask

  task automatic test_bad_opcode();
    logic [31:0] inst; logic err; logic [1:0] code; int lat;
    do_req(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, inst, err, code, lat);
    total++; if (inst !== 32'h0000_0013 || err !== 1'b1 || code !== 2'd3)
      $display("FAIL bad_opcode got %h/%b/%0d exp 00000013/1/3", inst, err, code); else passed++;
  endtask

  task automatic test_stall();
    int acc = 0;
    int k = 1;
    int unstable = 0;
    bit seen = 0;
    bit take;
    logic [31:0] held = '0;
    logic [31:0] outs[$];
    @(negedge i_clk);
    i_ready = 1'b0;
    set_req(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'(k));
    i_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (o_valid) begin
        if (!seen) begin held = o_inst; seen = 1; end
        else if (o_inst !== held || o_err !== 1'b0) unstable++;
      end
      take = o_ready;
      @(posedge i_clk);
      @(negedge i_clk);
      if (take) begin acc++; k++; i_imm = 32'(k); end
    end
    total++; if (acc !== 2) $display("FAIL stall_accepts got %0d exp 2", acc); else passed++;
    total++; if (!seen || unstable != 0)
      $display("FAIL stall_hold got seen=%0d changes=%0d exp seen=1 changes=0", seen, unstable); else passed++;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (o_valid) outs.push_back(o_inst);
      @(negedge i_clk);
    end
    total++; if (outs.size() != 2) $display("FAIL stall_count got %0d exp 2", outs.size()); else passed++;
    total++;
    if ((outs.size() > 0 ? outs[0] : 32'hx) !== 32'h0011_0093 ||
        (outs.size() > 1 ? outs[1] : 32'hx) !== 32'h0021_0093)
      $display("FAIL stall_order got %h,%h exp 00110093,00210093",
               outs.size() > 0 ? outs[0] : 32'hx, outs.size() > 1 ? outs[1] : 32'hx);
    else passed++;
  endtask

  task automatic gen_req();
    int f, v;
    logic [2:0] f3;
    f = $urandom_range(0, 4);
    f3 = 3'($urandom_range(0, 7));
    case (f)
      0: begin
        if (f3 == 3'b001 || f3 == 3'b101) f3 = 3'b000;
        v = int'($urandom_range(0, 4095)) - 2048;
        set_req(($urandom_range(0, 1) != 0) ? 7'b0010011 : 7'b0000011, 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'd0, f3, 7'd0, 32'(v));
      end
      1: begin
        v = int'($urandom_range(0, 4095)) - 2048;
        set_req(7'b0100011, 5'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                f3, 7'd0, 32'(v));
      end
      2: begin
        v = (int'($urandom_range(0, 4095)) - 2048) * 2;
        set_req(7'b1100011, 5'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                f3, 7'd0, 32'(v));
      end
      3: set_req(($urandom_range(0, 1) != 0) ? 7'b0110111 : 7'b0010111, 5'($urandom_range(0, 31)),
                 5'd0, 5'd0, 3'd0, 7'd0, $urandom() & 32'hFFFF_F000);
      default: begin
        v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
        set_req(7'b1101111, 5'($urandom_range(0, 31)), 5'd0, 5'd0, 3'd0, 7'd0, 32'(v));
      end
    endcase
  endtask

  task automatic test_stream_reset();
    logic [31:0] exp_imm[$];
    logic [6:0]  exp_op[$];
    logic [31:0] ei;
    logic [6:0]  eo;
    int xfers = 0;
    int bad = 0;
    int stale = 0;
    int n;
    bit took = 0;
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < ((ph == 2) ? 12 : 150); c++) begin
        @(negedge i_clk);
        if (took) i_valid = 1'b0;
        if (ph == 2) begin
          i_ready = 1'b1;
        end else begin
          i_ready = ($urandom_range(0, 3) != 0);
          if (!i_valid && $urandom_range(0, 3) != 0) begin
            gen_req();
            i_valid = 1'b1;
          end
        end
        #1;
        if (o_valid && i_ready) begin
          xfers++;
          if (exp_imm.size() == 0) begin
            bad++;
            $display("FAIL stream_extra got %h exp no output", o_inst);
          end else begin
            ei = exp_imm.pop_front();
            eo = exp_op.pop_front();
            total++;
            if (o_inst[6:0] !== eo || imm_dec(o_inst) !== ei || o_err !== 1'b0)
              $display("FAIL stream_roundtrip got op=%h imm=%h err=%b exp op=%h imm=%h err=0",
                       o_inst[6:0], imm_dec(o_inst), o_err, eo, ei);
            else passed++;
          end
        end
        took = i_valid && o_ready;
        if (took) begin
          exp_imm.push_back(i_imm);
          exp_op.push_back(i_opcode);
        end
      end
      if (ph == 0) begin
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ready = 1'b0;
        took = 0;
        n = 0;
        while (!o_valid && n < 20) begin @(negedge i_clk); n++; end
        i_rst_n = 1'b0;
        #1;
        total++; if (o_valid !== 1'b0 || n >= 20)
          $display("FAIL reset_midstream got o_valid=%b waited=%0d exp o_valid=0", o_valid, n); else passed++;
        exp_imm.delete();
        exp_op.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
          @(negedge i_clk);
          if (o_valid) stale++;
        end
        total++; if (stale != 0) $display("FAIL reset_stale got %0d outputs exp 0", stale); else passed++;
      end
    end
    total++; if (exp_imm.size() != 0 || bad != 0)
      $display("FAIL stream_drain got pending=%0d extra=%0d exp 0/0", exp_imm.size(), bad); else passed++;
    total++; if (xfers < 40) $display("FAIL stream_volume got %0d transfers exp >=40", xfers); else passed++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_beq();
    test_jal();
    test_srai();
    test_formats();
    test_bad_opcode();
    test_stall();
    test_stream_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
